// File: rtl/regfile_pkg.sv
// Shared register-file constants and bus types for the decode-stage register file.
package regfile_pkg;
    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;
    localparam int RegBusW    = 32;

    typedef logic [RegBusW-1:0]    RegBus;
    typedef logic [RegNumLog2-1:0] RegAddrBus;

    localparam RegBus ZeroWord    = '0;
    localparam logic  WriteEnable = 1'b1;
    localparam logic  ReadEnable  = 1'b1;
endpackage

// File: rtl/regfile_if.sv
// Decode/WB-facing bus of the register file: write-back port, two read ports, EX/MEM forwarding.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              ex_we;
    logic [ADDR_W-1:0] ex_waddr;
    logic [DATA_W-1:0] ex_wdata;
    logic              ex_is_load;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              stallreq;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
               ex_we, ex_waddr, ex_wdata, ex_is_load, mem_we, mem_waddr, mem_wdata,
        input  rdata1, rdata2, stallreq
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
               ex_we, ex_waddr, ex_wdata, ex_is_load, mem_we, mem_waddr, mem_wdata,
        output rdata1, rdata2, stallreq
    );
endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: youngest-producer forwarding mux plus load-use stall detection.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = RegBusW,
    parameter int ADDR_W = RegNumLog2
) (
    input  logic              rst_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [DATA_W-1:0] arr_word_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              port_stall_o
);
    always_comb begin
        rdata_o      = '0;
        port_stall_o = 1'b0;
        if (rst_i || re_i != ReadEnable || raddr_i == '0) begin
            rdata_o = '0;
        end else if (ex_we_i && ex_waddr_i == raddr_i) begin
            // A load in EX has no data yet: return 0 and hold decode a cycle.
            if (!ex_is_load_i) begin
                rdata_o = ex_wdata_i;
            end else begin
                port_stall_o = 1'b1;
            end
        end else if (mem_we_i && mem_waddr_i == raddr_i) begin
            rdata_o = mem_wdata_i;
        end else if (we_i == WriteEnable && waddr_i == raddr_i) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = arr_word_i;
        end
    end
endmodule

// File: rtl/regfile.sv
// 32 x 32 RISC-V integer register file: storage, WB write port, and two forwarding read ports.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RegBusW,
    parameter int ADDR_W   = RegNumLog2,
    parameter int NUM_REGS = RegNum
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] rdata1_d;
    logic [DATA_W-1:0] rdata2_d;
    logic              stall1_d;
    logic              stall2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.we == WriteEnable && bus.waddr != '0) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
        .rst_i        (rst),
        .re_i         (bus.re1),
        .raddr_i      (bus.raddr1),
        .arr_word_i   (mem_q[bus.raddr1]),
        .we_i         (bus.we),
        .waddr_i      (bus.waddr),
        .wdata_i      (bus.wdata),
        .ex_we_i      (bus.ex_we),
        .ex_waddr_i   (bus.ex_waddr),
        .ex_wdata_i   (bus.ex_wdata),
        .ex_is_load_i (bus.ex_is_load),
        .mem_we_i     (bus.mem_we),
        .mem_waddr_i  (bus.mem_waddr),
        .mem_wdata_i  (bus.mem_wdata),
        .rdata_o      (rdata1_d),
        .port_stall_o (stall1_d)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
        .rst_i        (rst),
        .re_i         (bus.re2),
        .raddr_i      (bus.raddr2),
        .arr_word_i   (mem_q[bus.raddr2]),
        .we_i         (bus.we),
        .waddr_i      (bus.waddr),
        .wdata_i      (bus.wdata),
        .ex_we_i      (bus.ex_we),
        .ex_waddr_i   (bus.ex_waddr),
        .ex_wdata_i   (bus.ex_wdata),
        .ex_is_load_i (bus.ex_is_load),
        .mem_we_i     (bus.mem_we),
        .mem_waddr_i  (bus.mem_waddr),
        .mem_wdata_i  (bus.mem_wdata),
        .rdata_o      (rdata2_d),
        .port_stall_o (stall2_d)
    );

    assign bus.rdata1   = rdata1_d;
    assign bus.rdata2   = rdata2_d;
    assign bus.stallreq = stall1_d | stall2_d;
endmodule

// File: tb/tb_regfile.sv
// Directed-vector bench for regfile: reset, write/readback, x0, forwarding priority, load-use stall.
module tb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    regfile_if rf_if ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rf_if.we = 1'b0;         rf_if.waddr = '0;     rf_if.wdata = '0;
        rf_if.re1 = 1'b0;        rf_if.raddr1 = '0;    rf_if.re2 = 1'b0;   rf_if.raddr2 = '0;
        rf_if.ex_we = 1'b0;      rf_if.ex_waddr = '0;  rf_if.ex_wdata = '0;
        rf_if.ex_is_load = 1'b0; rf_if.mem_we = 1'b0;  rf_if.mem_waddr = '0; rf_if.mem_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        rf_if.we = 1'b1; rf_if.waddr = a; rf_if.wdata = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        // Reset for two cycles; outputs held at 0 even with a forwarding source active.
        rst = 1'b1;
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd5;
        rf_if.ex_we = 1'b1; rf_if.ex_waddr = 5'd5; rf_if.ex_wdata = 32'hAAAA_5555;
        rf_if.re2 = 1'b1; rf_if.raddr2 = 5'd5; rf_if.ex_is_load = 1'b0;
        #1;
        chk("rst_rdata1", rf_if.rdata1, 32'h0);
        chk("rst_rdata2", rf_if.rdata2, 32'h0);
        rf_if.ex_is_load = 1'b1;
        #1;
        chk("rst_stall", {31'b0, rf_if.stallreq}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd5;
        #1;
        chk("post_rst_read5", rf_if.rdata1, 32'h0);
        chk("post_rst_stall", {31'b0, rf_if.stallreq}, 32'h0);

        // Write/readback, including same-cycle write-first bypass.
        idle();
        rf_if.we = 1'b1; rf_if.waddr = 5'd3; rf_if.wdata = 32'hDEAD_BEEF;
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd3;
        #1;
        chk("wb_bypass", rf_if.rdata1, 32'hDEAD_BEEF);
        tick();
        idle();
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd3;
        rf_if.re2 = 1'b1; rf_if.raddr2 = 5'd3;
        #1;
        chk("readback_p1", rf_if.rdata1, 32'hDEAD_BEEF);
        chk("readback_p2", rf_if.rdata2, 32'hDEAD_BEEF);
        rf_if.re1 = 1'b0;
        #1;
        chk("re1_off", rf_if.rdata1, 32'h0);

        // x0 is never written and never forwarded.
        idle();
        rf_if.we = 1'b1; rf_if.waddr = 5'd0; rf_if.wdata = 32'h0000_1234;
        rf_if.ex_we = 1'b1; rf_if.ex_waddr = 5'd0; rf_if.ex_wdata = 32'h0000_0055;
        rf_if.mem_we = 1'b1; rf_if.mem_waddr = 5'd0; rf_if.mem_wdata = 32'h0000_0066;
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd0;
        rf_if.re2 = 1'b1; rf_if.raddr2 = 5'd0;
        #1;
        chk("x0_fwd_p1", rf_if.rdata1, 32'h0);
        chk("x0_fwd_p2", rf_if.rdata2, 32'h0);
        tick();
        idle();
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd0;
        #1;
        chk("x0_array", rf_if.rdata1, 32'h0);

        // Forwarding priority: EX > MEM > WB > array.
        wr(5'd7, 32'd1);
        rf_if.we = 1'b1;     rf_if.waddr = 5'd7;     rf_if.wdata = 32'd2;
        rf_if.mem_we = 1'b1; rf_if.mem_waddr = 5'd7; rf_if.mem_wdata = 32'd3;
        rf_if.ex_we = 1'b1;  rf_if.ex_waddr = 5'd7;  rf_if.ex_wdata = 32'd4;
        rf_if.re1 = 1'b1;    rf_if.raddr1 = 5'd7;
        rf_if.re2 = 1'b1;    rf_if.raddr2 = 5'd7;
        #1;
        chk("fwd_ex", rf_if.rdata1, 32'd4);
        chk("fwd_ex_p2", rf_if.rdata2, 32'd4);
        rf_if.ex_we = 1'b0;
        #1;
        chk("fwd_mem", rf_if.rdata1, 32'd3);
        rf_if.mem_we = 1'b0;
        #1;
        chk("fwd_wb", rf_if.rdata1, 32'd2);
        rf_if.we = 1'b0;
        #1;
        chk("fwd_array", rf_if.rdata1, 32'd1);
        rf_if.ex_we = 1'b1; rf_if.ex_waddr = 5'd8; rf_if.ex_wdata = 32'd9;
        #1;
        chk("fwd_ex_other_reg", rf_if.rdata1, 32'd1);

        // Load-use hazard.
        idle();
        rf_if.ex_we = 1'b1; rf_if.ex_is_load = 1'b1; rf_if.ex_waddr = 5'd9; rf_if.ex_wdata = 32'h7777_7777;
        rf_if.mem_we = 1'b1; rf_if.mem_waddr = 5'd9; rf_if.mem_wdata = 32'h3333_3333;
        rf_if.re2 = 1'b1; rf_if.raddr2 = 5'd9;
        #1;
        chk("lu_stall_p2", {31'b0, rf_if.stallreq}, 32'h1);
        chk("lu_rdata2", rf_if.rdata2, 32'h0);
        rf_if.re2 = 1'b0;
        #1;
        chk("lu_re2_off", {31'b0, rf_if.stallreq}, 32'h0);
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd9;
        #1;
        chk("lu_stall_p1", {31'b0, rf_if.stallreq}, 32'h1);
        chk("lu_rdata1", rf_if.rdata1, 32'h0);
        rf_if.raddr1 = 5'd10;
        #1;
        chk("lu_other_reg", {31'b0, rf_if.stallreq}, 32'h0);
        rf_if.ex_is_load = 1'b0; rf_if.raddr1 = 5'd9;
        #1;
        chk("ex_alu_fwd", rf_if.rdata1, 32'h7777_7777);
        chk("ex_alu_nostall", {31'b0, rf_if.stallreq}, 32'h0);

        // Reset mid-write: the write on the reset edge is lost and storage clears.
        wr(5'd4, 32'h0000_0011);
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd4;
        #1;
        chk("pre_rst_reg4", rf_if.rdata1, 32'h0000_0011);
        rst = 1'b1;
        rf_if.we = 1'b1; rf_if.waddr = 5'd4; rf_if.wdata = 32'h0000_00FF;
        #1;
        chk("rst_wb_bypass", rf_if.rdata1, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd4;
        rf_if.re2 = 1'b1; rf_if.raddr2 = 5'd3;
        #1;
        chk("rst_lost_write", rf_if.rdata1, 32'h0);
        chk("rst_cleared_reg3", rf_if.rdata2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit RISC-V integer register file.
- Responder side of the decode stage's two register read ports (re/raddr -> rdata).
- Owns the single write-back port from the WB stage.
- Resolves read-after-write hazards: forwards in-flight EX/MEM/WB results to the read ports, and raises a stall request on a load-use hazard.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width in bits
NUM_REGS, 32, number of architectural registers (x0..x31)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
we  input  1  WB write enable
waddr  input  ADDR_W  WB destination register
wdata  input  DATA_W  WB write data
re1  input  1  read port 1 enable
raddr1  input  ADDR_W  read port 1 address
rdata1  output  DATA_W  read port 1 data
re2  input  1  read port 2 enable
raddr2  input  ADDR_W  read port 2 address
rdata2  output  DATA_W  read port 2 data
ex_we  input  1  EX stage result will be written
ex_waddr  input  ADDR_W  EX stage destination
ex_wdata  input  DATA_W  EX stage ALU result
ex_is_load  input  1  EX stage instruction is a load; data not yet available
mem_we  input  1  MEM stage result will be written
mem_waddr  input  ADDR_W  MEM stage destination
mem_wdata  input  DATA_W  MEM stage result, including load data
stallreq  output  1  load-use hazard; decode must hold for one cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Storage reset:
  - On a rising edge of clk with rst=1, all NUM_REGS entries are cleared to 0.
  - The WB write is ignored in that cycle.
- Write:
  - On a rising edge with rst=0, we=1 and waddr!=0: mem[waddr] <= wdata.
  - Writes to x0 are discarded.
  - Write latency is 1 cycle.
- Read ports: combinational, 0-cycle latency. Each port is evaluated independently, with this priority:
  1. rst=1 -> 0.
  2. re=0 -> 0.
  3. raddr=0 -> 0. This is never forwarded, even if a stage targets x0.
  4. ex_we=1 and ex_waddr=raddr:
     - if ex_is_load=0 -> ex_wdata;
     - else -> 0, and this port asserts the stall condition.
  5. mem_we=1 and mem_waddr=raddr -> mem_wdata.
  6. we=1 and waddr=raddr -> wdata. This is write-first bypass of the same-cycle write.
  7. Otherwise -> mem[raddr].
- Youngest producer wins: EX over MEM over WB over array.
- stallreq:
  - OR of both ports' stall conditions.
  - Combinational.
  - 0 during rst.
  - 0 when the matching port has re=0 or raddr=0.
- Simultaneous events:
  - Same address on both ports returns identical data.
  - WB write and read of the same register in one cycle returns the new wdata; the array also updates at the edge.
- Reset mid-operation: a write on the reset edge is lost, and outputs are 0 for the entire reset cycle.
- Outputs on reset: rdata1=0, rdata2=0, stallreq=0.

Decomposition:
- Constants in the shared defines file:
  - RegBus, RegAddrBus, RegNum (32), RegNumLog2 (5);
  - ZeroWord, WriteEnable, ReadEnable.
- One sub-module: regfile_read_port.
  - Holds the per-port priority mux and stall detection.
  - Instantiated twice; takes the array word, the forwarding buses and re/raddr.
  - Outputs rdata and port_stall.
- The storage array and write logic stay in regfile.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then re1=1 raddr1=5 -> rdata1=0, stallreq=0.
- Write/readback: we=1 waddr=3 wdata=0xDEADBEEF for 1 cycle, next cycle re1=1 raddr1=3 -> rdata1=0xDEADBEEF.
- x0 protection: write waddr=0 wdata=0x1234 with ex_we=1 ex_waddr=0 -> read raddr=0 gives 0.
- Forward priority:
  - stimulus: mem[7]=1, we=1 waddr=7 wdata=2, mem_we=1 mem_waddr=7 mem_wdata=3, ex_we=1 ex_waddr=7 ex_wdata=4 -> rdata1=4;
  - drop ex_we -> 3; drop mem_we -> 2.
- Load-use stall:
  - stimulus: ex_we=1 ex_is_load=1 ex_waddr=9, re2=1 raddr2=9 -> stallreq=1, rdata2=0;
  - same with re2=0 -> stallreq=0.
- Reset mid-write: rst=1 and we=1 waddr=4 wdata=0xFF on the same edge -> after rst drops, reg 4 reads 0.
